// File: rtl/soc_it_slave_arbiter.sv
// Round-robin arbiter sharing one SoC-IT slave port among NUM_REQ requesters.
// Optional watchdog abort: define SOC_IT_SLAVE_ARB_TIMEOUT_EN.
module soc_it_slave_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [64*NUM_REQ-1:0]    req_addr,
    input  logic [4*NUM_REQ-1:0]     req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [128*NUM_REQ-1:0]   wr_data,
    input  logic [16*NUM_REQ-1:0]    wr_be,
    output logic [NUM_REQ-1:0]       wr_ack,
    output logic [127:0]             rd_data,
    output logic [NUM_REQ-1:0]       rd_valid,
    output logic                     timeout_err,
    output logic [63:0]              slave_address,
    output logic [3:0]               slave_transaction_id,
    output logic                     slave_address_valid,
    input  logic                     slave_address_ack,
    output logic [3:0]               slave_wrreq,
    input  logic                     slave_wrack,
    output logic [15:0]              slave_be,
    output logic [127:0]             slave_datain,
    output logic [3:0]               slave_rdreq,
    input  logic                     slave_rdack,
    input  logic [127:0]             slave_dataout
);

    // state | meaning
    // IDLE  | no transaction; arbitrate among req_valid
    // ADDR  | address phase, waiting for slave_address_ack
    // WDATA | write beats, one per slave_wrack
    // RDATA | read beats, one per slave_rdack
    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   g;
    logic [3:0]         len;
    logic [3:0]         cnt;
    logic               is_write;

    logic [IDX_W-1:0]   grant_c;
    logic               grant_vld_c;
    logic [3:0]         len_c;
    logic [NUM_REQ-1:0] g_onehot;

    logic [63:0]  addr_a [NUM_REQ];
    logic [3:0]   len_a  [NUM_REQ];
    logic [127:0] wd_a   [NUM_REQ];
    logic [15:0]  be_a   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[64*i +: 64];
        assign len_a[i]  = req_len[4*i +: 4];
        assign wd_a[i]   = wr_data[128*i +: 128];
        assign be_a[i]   = wr_be[16*i +: 16];
    end

    // First set request searching upward from ptr+1 with wrap-around
    always_comb begin : rr_search
        int               idx;
        logic [IDX_W-1:0] idx_l;
        grant_c     = '0;
        grant_vld_c = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(ptr) + k) % NUM_REQ;
            idx_l = IDX_W'(idx);
            if (!grant_vld_c && req_valid[idx_l]) begin
                grant_vld_c = 1'b1;
                grant_c     = idx_l;
            end
        end
    end

    assign len_c    = (len_a[grant_c] == 4'd0) ? 4'd1 : len_a[grant_c];
    assign g_onehot = NUM_REQ'(1) << g;

    assign req_ready    = (state == ADDR  && slave_address_ack) ? g_onehot : '0;
    assign wr_ack       = (state == WDATA && slave_wrack)       ? g_onehot : '0;
    assign slave_datain = (state == WDATA) ? wd_a[g] : '0;
    assign slave_be     = (state == WDATA) ? be_a[g] : '0;

`ifdef SOC_IT_SLAVE_ARB_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
    logic [WD_W-1:0] wd;
    logic            phase_ack;
    logic            wd_fire;

    assign phase_ack = (state == ADDR  && slave_address_ack) ||
                       (state == WDATA && slave_wrack) ||
                       (state == RDATA && slave_rdack);
    assign wd_fire   = (state != IDLE) && !phase_ack && (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            ptr                  <= IDX_W'(NUM_REQ - 1);
            g                    <= '0;
            len                  <= '0;
            cnt                  <= '0;
            is_write             <= 1'b0;
            rd_data              <= '0;
            rd_valid             <= '0;
            slave_address        <= '0;
            slave_transaction_id <= '0;
            slave_address_valid  <= 1'b0;
            slave_wrreq          <= '0;
            slave_rdreq          <= '0;
`ifdef SOC_IT_SLAVE_ARB_TIMEOUT_EN
            wd                   <= '0;
            timeout_err          <= 1'b0;
`endif
        end else begin
            rd_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_vld_c) begin
                        g                    <= grant_c;
                        ptr                  <= grant_c;
                        slave_address        <= addr_a[grant_c];
                        slave_transaction_id <= 4'(grant_c);
                        slave_address_valid  <= 1'b1;
                        len                  <= len_c;
                        is_write             <= req_write[grant_c];
                        state                <= ADDR;
                    end
                end
                ADDR: begin
                    if (slave_address_ack) begin
                        slave_address_valid <= 1'b0;
                        cnt                 <= len;
                        if (is_write) begin
                            slave_wrreq <= len;
                            state       <= WDATA;
                        end else begin
                            slave_rdreq <= len;
                            state       <= RDATA;
                        end
                    end
                end
                WDATA: begin
                    if (slave_wrack) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            slave_wrreq <= '0;
                            state       <= IDLE;
                        end
                    end
                end
                RDATA: begin
                    if (slave_rdack) begin
                        rd_data  <= slave_dataout;
                        rd_valid <= g_onehot;
                        cnt      <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            slave_rdreq <= '0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SOC_IT_SLAVE_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            if (state == IDLE || phase_ack)
                wd <= '0;
            else
                wd <= wd + 1'b1;
            // Abort overrides the case above; pointer stays on the aborted requester
            if (wd_fire) begin
                state               <= IDLE;
                slave_address_valid <= 1'b0;
                slave_wrreq         <= '0;
                slave_rdreq         <= '0;
                timeout_err         <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_soc_it_slave_arbiter.sv
// Scoreboard bench for soc_it_slave_arbiter; the watchdog case runs when
// SOC_IT_SLAVE_ARB_TIMEOUT_EN is defined.
module tb_soc_it_slave_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_write, req_ready, wr_ack, rd_valid;
    logic [64*N-1:0]  req_addr;
    logic [4*N-1:0]   req_len;
    logic [128*N-1:0] wr_data;
    logic [16*N-1:0]  wr_be;
    logic [127:0]   rd_data, slave_datain, slave_dataout;
    logic           timeout_err, slave_address_valid, slave_address_ack;
    logic           slave_wrack, slave_rdack;
    logic [63:0]    slave_address;
    logic [3:0]     slave_transaction_id, slave_wrreq, slave_rdreq;
    logic [15:0]    slave_be;

    int checks = 0;
    int failures = 0;

    typedef struct packed { logic [3:0] id; logic [63:0] addr; } addr_t;
    typedef struct packed { logic [3:0] id; logic [15:0] be; logic [127:0] data; } beat_t;
    addr_t q_addr[$];
    beat_t q_wr[$];
    beat_t q_rd[$];

    soc_it_slave_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_len(req_len), .req_ready(req_ready),
        .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
        .rd_data(rd_data), .rd_valid(rd_valid), .timeout_err(timeout_err),
        .slave_address(slave_address), .slave_transaction_id(slave_transaction_id),
        .slave_address_valid(slave_address_valid), .slave_address_ack(slave_address_ack),
        .slave_wrreq(slave_wrreq), .slave_wrack(slave_wrack),
        .slave_be(slave_be), .slave_datain(slave_datain),
        .slave_rdreq(slave_rdreq), .slave_rdack(slave_rdack),
        .slave_dataout(slave_dataout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: address acceptances, write beats and read beats popped in order
    always @(negedge clk) begin : mon
        addr_t a;
        beat_t b;
        if (rst) begin
            if (slave_address_valid && slave_address_ack) begin
                if (q_addr.size() == 0) check("addr_unexpected", 1, 0);
                else begin
                    a = q_addr.pop_front();
                    check("txn_id", slave_transaction_id, a.id);
                    check("addr", slave_address, a.addr);
                    check("req_ready", req_ready, 128'(1) << a.id);
                end
            end
            if (wr_ack != 0) begin
                if (q_wr.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    b = q_wr.pop_front();
                    check("wr_ack", wr_ack, 128'(1) << b.id);
                    check("datain", slave_datain, b.data);
                    check("be", slave_be, b.be);
                end
            end
            if (rd_valid != 0) begin
                if (q_rd.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    b = q_rd.pop_front();
                    check("rd_valid", rd_valid, 128'(1) << b.id);
                    check("rd_data", rd_data, b.data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_av(output int n);
        n = 0;
        while (!slave_address_valid && n < 50) begin
            cyc();
            n++;
        end
        if (!slave_address_valid) check("av_wait_expired", 0, 1);
    endtask

    task automatic addr_ack(input int id);
        slave_address_ack = 1'b1;
        cyc();
        slave_address_ack = 1'b0;
        req_valid[id] = 1'b0;
    endtask

    task automatic rd_beat(input logic [127:0] d);
        int n = 0;
        while (slave_rdreq == 0 && n < 50) begin
            cyc();
            n++;
        end
        if (slave_rdreq == 0) check("rdreq_wait_expired", 0, 1);
        slave_dataout = d;
        slave_rdack   = 1'b1;
        cyc();
        slave_rdack   = 1'b0;
    endtask

    task automatic push_addr(input int id, input logic [63:0] a);
        addr_t e;
        e.id = 4'(id);
        e.addr = a;
        q_addr.push_back(e);
    endtask

    task automatic push_beat(input bit wr, input int id, input logic [15:0] be, input logic [127:0] d);
        beat_t e;
        e.id = 4'(id);
        e.be = be;
        e.data = d;
        if (wr) q_wr.push_back(e);
        else    q_rd.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        logic [127:0] w;
        rst = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_be = '0;
        slave_address_ack = 1'b0; slave_wrack = 1'b0; slave_rdack = 1'b0;
        slave_dataout = '0;
        repeat (3) cyc();
        check("rst_av", slave_address_valid, 0);
        check("rst_id", slave_transaction_id, 0);
        check("rst_addr", slave_address, 0);
        check("rst_wrreq", slave_wrreq, 0);
        check("rst_rdreq", slave_rdreq, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b1;
        cyc();

        // All four requesters, reads of one beat: grants 0,1,2,3 with one IDLE gap
        for (int i = 0; i < N; i++) begin
            req_addr[64*i +: 64] = 64'h100 * (i + 1);
            push_addr(i, 64'h100 * (i + 1));
            push_beat(0, i, 16'h0, 128'hD0 + 128'(i));
        end
        req_len = 16'h1111;
        req_valid = 4'hF;
        for (int t = 0; t < N; t++) begin
            wait_av(n);
            check("grant_gap", n, 1);
            addr_ack(t);
            check("rdreq_len1", slave_rdreq, 1);
            rd_beat(128'hD0 + 128'(t));
            check("rdreq_done", slave_rdreq, 0);
        end

        // Requester 2 write of 3 beats, late address ack, wrack every other cycle
        wr_data = {4{128'hBAD0_BAD0}};
        wr_be = {4{16'hFFFF}};
        req_addr[128 +: 64] = 64'h1000;
        req_len[8 +: 4] = 4'd3;
        req_write[2] = 1'b1;
        push_addr(2, 64'h1000);
        for (int b = 0; b < 3; b++)
            push_beat(1, 2, 16'h00F0 + 16'(b), {4{32'hA000_0000 + 32'(b)}});
        req_valid = 4'b0100;
        wait_av(n);
        repeat (5) cyc();
        check("av_hold", slave_address_valid, 1);
        check("addr_hold", slave_address, 64'h1000);
        addr_ack(2);
        check("wrreq_len3", slave_wrreq, 3);
        for (int b = 0; b < 3; b++) begin
            wr_data[256 +: 128] = {4{32'hA000_0000 + 32'(b)}};
            wr_be[32 +: 16] = 16'h00F0 + 16'(b);
            cyc();
            check("wrreq_hold", slave_wrreq, 3);
            slave_wrack = 1'b1;
            cyc();
            slave_wrack = 1'b0;
        end
        check("wrreq_done", slave_wrreq, 0);
        req_write = '0;

        // Requester 1 read of 2 beats
        req_addr[64 +: 64] = 64'h2000;
        req_len[4 +: 4] = 4'd2;
        push_addr(1, 64'h2000);
        push_beat(0, 1, 16'h0, 128'hAAAA_0001);
        push_beat(0, 1, 16'h0, 128'hBBBB_0002);
        req_valid = 4'b0010;
        wait_av(n);
        addr_ack(1);
        check("rdreq_len2", slave_rdreq, 2);
        rd_beat(128'hAAAA_0001);
        check("rdreq_mid", slave_rdreq, 2);
        cyc();
        rd_beat(128'hBBBB_0002);
        check("rdreq_end", slave_rdreq, 0);

        // len=0 write from requester 0 is a single beat
        req_addr[0 +: 64] = 64'h3000;
        req_len[0 +: 4] = 4'd0;
        req_write[0] = 1'b1;
        wr_data[0 +: 128] = 128'hC0DE_0000;
        wr_be[0 +: 16] = 16'h8001;
        push_addr(0, 64'h3000);
        push_beat(1, 0, 16'h8001, 128'hC0DE_0000);
        req_valid = 4'b0001;
        wait_av(n);
        addr_ack(0);
        check("wrreq_len0", slave_wrreq, 1);
        slave_wrack = 1'b1;
        cyc();
        slave_wrack = 1'b0;
        check("wrreq_len0_done", slave_wrreq, 0);

        // Reset during beat 2 of a 4-beat write
        req_addr[0 +: 64] = 64'h4000;
        req_len[0 +: 4] = 4'd4;
        wr_data[0 +: 128] = 128'h4444_0001;
        push_addr(0, 64'h4000);
        push_beat(1, 0, 16'h8001, 128'h4444_0001);
        req_valid = 4'b0001;
        wait_av(n);
        addr_ack(0);
        check("wrreq_len4", slave_wrreq, 4);
        slave_wrack = 1'b1;
        cyc();
        wr_data[0 +: 128] = 128'h4444_0002;
        #2 rst = 1'b0;
        #1;
        check("arst_wrreq", slave_wrreq, 0);
        check("arst_wr_ack", wr_ack, 0);
        check("arst_datain", slave_datain, 0);
        check("arst_be", slave_be, 0);
        check("arst_av", slave_address_valid, 0);
        check("arst_addr", slave_address, 0);
        slave_wrack = 1'b0;
        req_valid = '0;
        req_write = '0;
        repeat (2) cyc();
        rst = 1'b1;
        req_addr[192 +: 64] = 64'h5000;
        push_addr(3, 64'h5000);
        push_beat(0, 3, 16'h0, 128'h5555);
        req_valid = 4'b1000;
        wait_av(n);
        check("post_rst_id", slave_transaction_id, 3);
        addr_ack(3);
        rd_beat(128'h5555);

`ifdef SOC_IT_SLAVE_ARB_TIMEOUT_EN
        // Address never acked: abort after 16 cycles, requester 1 is next
        req_addr[0 +: 64] = 64'h6000;
        req_addr[64 +: 64] = 64'h7000;
        req_len[7:0] = 8'h11;
        push_addr(1, 64'h7000);
        push_beat(0, 1, 16'h0, 128'h7777);
        req_valid = 4'b0011;
        wait_av(n);
        check("to_first_id", slave_transaction_id, 0);
        n = 0;
        while (!timeout_err && n < 40) begin
            cyc();
            n++;
        end
        check("to_cycles", n, 16);
        check("to_av", slave_address_valid, 0);
        cyc();
        check("to_pulse_width", timeout_err, 0);
        wait_av(n);
        check("to_next_id", slave_transaction_id, 1);
        req_valid[0] = 1'b0;
        addr_ack(1);
        rd_beat(128'h7777);
`endif

        repeat (3) cyc();
        check("q_addr_empty", q_addr.size(), 0);
        check("q_wr_empty", q_wr.size(), 0);
        check("q_rd_empty", q_rd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
